uart_tx: RTL and testbench

UART transmitter: the transmit-side counterpart to the board's UART receive path. Accepts bytes from the design logic over a valid/ready handshake, buffers them in a small FIFO, and serialises each one on a single line as 8N1 frames: start bit, 8 data bits LSB first, optional parity, one stop bit. Sits in the 25.175 MHz pixel-clock domain next to the logic and drawer blocks, driving the board's UART TX pin.

---
 rtl/uart_tx.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-oriented UART transmitter with a small circular FIFO.
// Frames are start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and one even-parity bit).
// The serial line, busy flag and all FSM state are registered; data_in_ready is
// decoded directly from the registered FIFO count.

module uart_tx #(
    parameter int CLKS_PER_BIT    = 218,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       uart_tx_out,
    output logic       busy
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   BAUD_ONE  = 16'd1;
    localparam logic [15:0]   BAUD_ZERO = 16'd0;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [2:0]    BIT_LAST  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd3
`endif
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;

    // Transmit FSM
    state_t        state_r;
    state_t        state_next_s;
    logic [15:0]   baud_r;
    logic [15:0]   baud_next_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic          line_r;
    logic          line_next_s;
    logic          busy_r;
    logic          baud_done_s;
`ifdef UART_TX_PARITY_EN
    logic          parity_r;
    logic          parity_next_s;
`endif

    assign data_in_ready = (count_r != CNT_FULL);
    assign push_s        = data_in_valid && data_in_ready;
    assign fifo_empty_s  = (count_r == CNT_ZERO);
    assign uart_tx_out   = line_r;
    assign busy          = busy_r;

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers and count; pointers wrap naturally at the depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // FIFO data array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Next-state and next-line logic of the frame sequencer.
    always_comb begin
        state_next_s = state_r;
        baud_next_s  = baud_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        line_next_s  = line_r;
        pop_s        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next_s = parity_r;
`endif
        baud_done_s  = (baud_r == BAUD_LAST);

        case (state_r)
            ST_IDLE: begin
                line_next_s = 1'b1;
                baud_next_s = BAUD_ZERO;
                bit_next_s  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
                    parity_next_s = even_parity(mem_r[rd_ptr_r]);
`endif
                    state_next_s = ST_START;
                    line_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (baud_done_s) begin
                    baud_next_s  = BAUD_ZERO;
                    bit_next_s   = 3'd0;
                    state_next_s = ST_DATA;
                    line_next_s  = shift_r[0];
                end else begin
                    baud_next_s = baud_r + BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (baud_done_s) begin
                    baud_next_s = BAUD_ZERO;
                    if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next_s = ST_PARITY;
                        line_next_s  = parity_r;
`else
                        state_next_s = ST_STOP;
                        line_next_s  = 1'b1;
`endif
                    end else begin
                        shift_next_s = shift_r >> 3'd1;
                        line_next_s  = shift_r[1];
                        bit_next_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_next_s = baud_r + BAUD_ONE;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done_s) begin
                    baud_next_s  = BAUD_ZERO;
                    state_next_s = ST_STOP;
                    line_next_s  = 1'b1;
                end else begin
                    baud_next_s = baud_r + BAUD_ONE;
                end
            end
`endif

            ST_STOP: begin
                if (baud_done_s) begin
                    baud_next_s = BAUD_ZERO;
                    if (!fifo_empty_s) begin
                        // Back-to-back frame: no idle gap after the stop bit.
                        pop_s        = 1'b1;
                        shift_next_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
                        parity_next_s = even_parity(mem_r[rd_ptr_r]);
`endif
                        state_next_s = ST_START;
                        line_next_s  = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                        line_next_s  = 1'b1;
                    end
                end else begin
                    baud_next_s = baud_r + BAUD_ONE;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
                baud_next_s  = BAUD_ZERO;
                bit_next_s   = 3'd0;
                line_next_s  = 1'b1;
            end
        endcase
    end

    // Sequencer state register; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            line_r  <= 1'b1;
            busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            baud_r  <= baud_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
            line_r  <= line_next_s;
            busy_r  <= (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of accepted bytes checked against a
// line-level receiver model, plus timing checks on start bits, busy and ready.
// Honours UART_TX_PARITY_EN for frame length and parity checking.

module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       uart_tx_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         rx_frames = 0;
    int         line_lows = 0;

    uart_tx #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .uart_tx_out  (uart_tx_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Edge counter used as the timing reference for all latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Receiver model: samples the line mid-bit and scores each decoded frame.
    initial begin : rx_model
        logic       act;
        int         k;
        int         b;
        logic [7:0] rx_byte;
        act = 1'b0;
        k = 0;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
            end else begin
                if (uart_tx_out == 1'b0) line_lows++;
                if (!act) begin
                    if (uart_tx_out == 1'b0) begin
                        act = 1'b1;
                        k = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    k++;
                end
                if (act && (k % CPB == CPB / 2)) begin
                    b = k / CPB;
                    if (b == 0) begin
                        check_eq("rx_start_bit", {31'd0, uart_tx_out}, 32'd0);
                    end else if (b <= 8) begin
                        rx_byte[b-1] = uart_tx_out;
`ifdef UART_TX_PARITY_EN
                    end else if (b == 9) begin
                        check_eq("rx_parity", {31'd0, uart_tx_out}, {31'd0, ^rx_byte});
`endif
                    end else begin
                        check_eq("rx_stop_bit", {31'd0, uart_tx_out}, 32'd1);
                        check_eq("rx_expected_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                        if (exp_q.size() != 0) begin
                            check_eq("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                        end
                        rx_frames++;
                        act = 1'b0;
                    end
                end
            end
        end
    end

    // Offer a byte until accepted or the budget expires; starts just after a posedge.
    task automatic push_byte(input logic [7:0] b, input int max_wait, output logic ok, output int acc);
        ok = 1'b0;
        acc = -1;
        data_in = b;
        data_in_valid = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (data_in_ready) begin
                @(posedge clk);
                #1;
                exp_q.push_back(b);
                acc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
    endtask

    // Wait for busy to drop, reporting the edge after which it fell.
    task automatic wait_idle(input int budget, output int fall);
        fall = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                fall = cyc;
                break;
            end
        end
        if (fall < 0) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000; i++) begin
            if (cyc >= target) break;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic ok;
        int   n;
        int   n0;
        int   acc;
        int   fall;
        int   s0;
        int   f0;
        int   lows0;
        int   sa;
        int   e;

        rst_n = 1'b0;
        data_in = 8'h00;
        data_in_valid = 1'b0;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("reset_line", {31'd0, uart_tx_out}, 32'd1);
        check_eq("reset_ready", {31'd0, data_in_ready}, 32'd1);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        lows0 = line_lows;
        repeat (10) @(negedge clk);
        check_eq("idle_no_activity", line_lows - lows0, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Single byte 0xA5: start after N+1, busy falls exactly one frame later
        @(posedge clk);
        #1;
        s0 = start_q.size();
        f0 = rx_frames;
        push_byte(8'hA5, 10, ok, n);
        check_eq("t1_accept", {31'd0, ok}, 32'd1);
        check_eq("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle(FRAME + 20, fall);
        check_eq("t1_start_cycle", start_q[s0], n + 1);
        check_eq("t1_busy_fall", fall, n + 1 + FRAME);
        check_eq("t1_frames", rx_frames - f0, 32'd1);

        // FIFO fill: one byte in flight plus four queued makes the FIFO full
        @(posedge clk);
        #1;
        s0 = start_q.size();
        f0 = rx_frames;
        push_byte(8'h00, 1, ok, n0);
        check_eq("t2_acc_0", {31'd0, ok}, 32'd1);
        push_byte(8'hFF, 1, ok, acc);
        check_eq("t2_acc_1", {31'd0, ok}, 32'd1);
        push_byte(8'h55, 1, ok, acc);
        check_eq("t2_acc_2", {31'd0, ok}, 32'd1);
        push_byte(8'h3C, 1, ok, acc);
        check_eq("t2_acc_3", {31'd0, ok}, 32'd1);
        push_byte(8'h96, 1, ok, acc);
        check_eq("t2_acc_4", {31'd0, ok}, 32'd1);
        check_eq("t2_consecutive", acc, n0 + 4);
        @(negedge clk);
        check_eq("t2_full_not_ready", {31'd0, data_in_ready}, 32'd0);
        push_byte(8'hC3, FRAME + 20, ok, acc);
        check_eq("t2_held_accept", {31'd0, ok}, 32'd1);
        check_eq("t2_held_accept_cycle", acc, n0 + 1 + FRAME + 1);
        wait_idle(7 * FRAME, fall);
        check_eq("t2_frames", rx_frames - f0, 32'd6);
        for (int i = 1; i < 6; i++) begin
            check_eq("t2_no_gap", start_q[s0 + i] - start_q[s0 + i - 1], FRAME);
        end

        // Pointer wrap: 20 bytes streamed through the 4-entry FIFO
        @(posedge clk);
        #1;
        f0 = rx_frames;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(i), 2 * FRAME, ok, acc);
            check_eq("t3_accept", {31'd0, ok}, 32'd1);
        end
        wait_idle(6 * FRAME, fall);
        check_eq("t3_frames", rx_frames - f0, 32'd20);

        // Simultaneous push and pop on the edge that ends a stop bit
        @(posedge clk);
        #1;
        s0 = start_q.size();
        f0 = rx_frames;
        push_byte(8'h6B, 1, ok, n);
        push_byte(8'h9E, 1, ok, acc);
        e = n + 1 + FRAME;
        wait_until(e - 1);
        push_byte(8'h47, 2, ok, acc);
        check_eq("t4_push_on_pop_edge", acc, e);
        check_eq("t4_ready_kept", {31'd0, data_in_ready}, 32'd1);
        wait_idle(4 * FRAME, fall);
        check_eq("t4_frames", rx_frames - f0, 32'd3);
        check_eq("t4_second_start", start_q[s0 + 1], e);
        check_eq("t4_third_start", start_q[s0 + 2], e + FRAME);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);

        // Reset mid-frame during data bit3 of 0x81 with two bytes queued
        @(posedge clk);
        #1;
        push_byte(8'h81, 1, ok, n);
        push_byte(8'h11, 1, ok, acc);
        push_byte(8'h22, 1, ok, acc);
        sa = n + 1;
        wait_until(sa + 4 * CPB + 1);
        #2;
        check_eq("t5_pre_reset_line", {31'd0, uart_tx_out}, 32'd0);
        check_eq("t5_pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("t5_reset_line", {31'd0, uart_tx_out}, 32'd1);
        check_eq("t5_reset_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_reset_ready", {31'd0, data_in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        f0 = rx_frames;
        lows0 = line_lows;
        repeat (3 * FRAME) @(negedge clk);
        check_eq("t5_no_frames", rx_frames - f0, 32'd0);
        check_eq("t5_line_quiet", line_lows - lows0, 32'd0);
        check_eq("t5_busy_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
